// File: rtl/alu_seq_pkg.sv
// Shared definitions for the ALU sequencing controller: state encoding,
// instruction field layout and default widths.
package alu_seq_pkg;

    localparam int unsigned OP_W_DEFAULT  = 4;
    localparam int unsigned CNT_W_DEFAULT = 16;
    localparam int unsigned REG_ADDR_W    = 5;

    // Instruction word layout, LSB first: rt, rs, rd, alu_op, wb (MSB).
    localparam int unsigned RT_LSB = 0;
    localparam int unsigned RS_LSB = RT_LSB + REG_ADDR_W;
    localparam int unsigned RD_LSB = RS_LSB + REG_ADDR_W;
    localparam int unsigned OP_LSB = RD_LSB + REG_ADDR_W;

    // Total instruction width for a given opcode width.
    function automatic int unsigned instr_width(input int unsigned op_w);
        return OP_LSB + op_w + 1;
    endfunction

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_READ  = 3'd1,
        ST_EXEC  = 3'd2,
        ST_WRITE = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

endpackage : alu_seq_pkg

// File: rtl/alu_seq_ctrl.sv
// ALU sequencing controller: accepts one instruction word, then walks it
// through READ (load operands), EXEC (load result/flags), WRITE (register
// file write) and DONE (retire + count).
// Optional build macro ALU_SEQ_R0_PROTECT_EN: suppress register-file writes
// to address 0 while still retiring and counting the instruction.
module alu_seq_ctrl
    import alu_seq_pkg::*;
#(
    parameter int unsigned OP_W  = OP_W_DEFAULT,
    parameter int unsigned CNT_W = CNT_W_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  instr_valid,
    input  logic [OP_W+15:0]      instr,
    output logic                  instr_ready,
    input  logic                  hold,
    output logic [REG_ADDR_W-1:0] R_Addr_A,
    output logic [REG_ADDR_W-1:0] R_Addr_B,
    output logic [REG_ADDR_W-1:0] W_Addr,
    output logic [OP_W-1:0]       ALU_OP,
    output logic                  ld_ab,
    output logic                  ld_f,
    output logic                  Reg_Write,
    output logic                  busy,
    output logic                  done,
    output logic [CNT_W-1:0]      instr_count
);

    localparam int unsigned INSTR_W = instr_width(OP_W);
    localparam int unsigned WB_BIT  = INSTR_W - 1;

    state_e state;
    logic   wr_en_q;
    logic   wr_allow_c;
    logic   strobe_en_c;

    // Decide at capture time whether this instruction may write the register file.
`ifdef ALU_SEQ_R0_PROTECT_EN
    assign wr_allow_c = instr[WB_BIT] && (instr[RD_LSB +: REG_ADDR_W] != '0);
`else
    assign wr_allow_c = instr[WB_BIT];
`endif

    // Acceptance is possible only from IDLE and never while frozen.
    assign instr_ready = (state == ST_IDLE) && !hold;

    // Strobes are the registered state decoded, silenced while frozen or in reset.
    // A state only advances on a cycle where its strobe is actually shown, so
    // each strobe fires exactly once per instruction even across a hold.
    assign strobe_en_c = !hold && !rst;
    assign ld_ab       = strobe_en_c && (state == ST_READ);
    assign ld_f        = strobe_en_c && (state == ST_EXEC);
    assign Reg_Write   = strobe_en_c && (state == ST_WRITE) && wr_en_q;
    assign done        = strobe_en_c && (state == ST_DONE);

    // Sequencer: state register, field latch, busy flag and retirement counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            R_Addr_A    <= '0;
            R_Addr_B    <= '0;
            W_Addr      <= '0;
            ALU_OP      <= '0;
            wr_en_q     <= 1'b0;
            busy        <= 1'b0;
            instr_count <= '0;
        end else if (!hold) begin
            unique case (state)
                ST_IDLE: begin
                    if (instr_valid) begin
                        R_Addr_A <= instr[RS_LSB +: REG_ADDR_W];
                        R_Addr_B <= instr[RT_LSB +: REG_ADDR_W];
                        W_Addr   <= instr[RD_LSB +: REG_ADDR_W];
                        ALU_OP   <= instr[OP_LSB +: OP_W];
                        wr_en_q  <= wr_allow_c;
                        busy     <= 1'b1;
                        state    <= ST_READ;
                    end
                end
                ST_READ: begin
                    state <= ST_EXEC;
                end
                ST_EXEC: begin
                    state <= ST_WRITE;
                end
                ST_WRITE: begin
                    state <= ST_DONE;
                end
                ST_DONE: begin
                    instr_count <= instr_count + CNT_W'(1);
                    busy        <= 1'b0;
                    state       <= ST_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule : alu_seq_ctrl

// File: tb/tb_alu_seq_ctrl.sv
// Bench for alu_seq_ctrl: cycle-level behavioural model plus directed
// sequences with hand-computed expectations.
module tb_alu_seq_ctrl;

    localparam int unsigned OP_W    = 4;
    localparam int unsigned CNT_W   = 4;
    localparam int unsigned CNT_MOD = 1 << CNT_W;
`ifdef ALU_SEQ_R0_PROTECT_EN
    localparam bit R0_PROT = 1'b1;
`else
    localparam bit R0_PROT = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic             instr_valid;
    logic [OP_W+15:0] instr;
    logic             instr_ready;
    logic             hold;
    logic [4:0]       R_Addr_A;
    logic [4:0]       R_Addr_B;
    logic [4:0]       W_Addr;
    logic [OP_W-1:0]  ALU_OP;
    logic             ld_ab;
    logic             ld_f;
    logic             Reg_Write;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] instr_count;

    int checks = 0;
    int errors = 0;

    alu_seq_ctrl #(.OP_W(OP_W), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .instr_valid (instr_valid),
        .instr       (instr),
        .instr_ready (instr_ready),
        .hold        (hold),
        .R_Addr_A    (R_Addr_A),
        .R_Addr_B    (R_Addr_B),
        .W_Addr      (W_Addr),
        .ALU_OP      (ALU_OP),
        .ld_ab       (ld_ab),
        .ld_f        (ld_f),
        .Reg_Write   (Reg_Write),
        .busy        (busy),
        .done        (done),
        .instr_count (instr_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] strobes();
        return {done, Reg_Write, ld_f, ld_ab};
    endfunction

    function automatic logic [19:0] mk(input int wb, input int op, input int rd,
                                       input int rs, input int rt);
        return {1'(wb), 4'(op), 5'(rd), 5'(rs), 5'(rt)};
    endfunction

    // Behavioural model: an accepted instruction owes four strobes in order,
    // one per unheld cycle; the count is the number retired modulo 2^CNT_W.
    bit          chk_en = 1'b0;
    bit          m_act  = 1'b0;
    int          m_step = 0;
    bit          m_wb   = 1'b0;
    logic [3:0]  m_op   = '0;
    logic [4:0]  m_rd   = '0;
    logic [4:0]  m_rs   = '0;
    logic [4:0]  m_rt   = '0;
    int unsigned m_cnt  = 0;

    always @(posedge clk) begin
        if (rst) begin
            m_act = 1'b0; m_step = 0; m_wb = 1'b0;
            m_op = '0; m_rd = '0; m_rs = '0; m_rt = '0;
            m_cnt = 0;
            chk_en = 1'b1;
        end else if (!hold) begin
            if (!m_act) begin
                if (instr_valid) begin
                    m_act = 1'b1;
                    m_step = 0;
                    {m_wb, m_op, m_rd, m_rs, m_rt} = instr;
                end
            end else if (m_step == 3) begin
                m_act = 1'b0;
                m_cnt = (m_cnt + 1) % CNT_MOD;
            end else begin
                m_step++;
            end
        end
    end

    // Compare every output against the model mid-cycle.
    always @(negedge clk) begin
        logic [3:0] es;
        if (chk_en) begin
            es = '0;
            if (m_act && !hold && !rst) begin
                es[m_step] = 1'b1;
                if (m_step == 2 && !(m_wb && (!R0_PROT || m_rd != 0)))
                    es[2] = 1'b0;
            end
            chk("m_ready",   32'(instr_ready), 32'(!m_act && !hold));
            chk("m_busy",    32'(busy),        32'(m_act));
            chk("m_strobes", 32'(strobes()),   32'(es));
            chk("m_addr_a",  32'(R_Addr_A),    32'(m_rs));
            chk("m_addr_b",  32'(R_Addr_B),    32'(m_rt));
            chk("m_waddr",   32'(W_Addr),      32'(m_rd));
            chk("m_aluop",   32'(ALU_OP),      32'(m_op));
            chk("m_count",   32'(instr_count), 32'(m_cnt));
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic issue(input logic [19:0] w);
        instr_valid = 1'b1;
        instr = w;
        cyc();
        instr_valid = 1'b0;
    endtask

    // Four consecutive cycles of strobes, cycle k expects pat[4k +: 4].
    task automatic expect_strobes(input string tag, input logic [15:0] pat);
        for (int k = 0; k < 4; k++) begin
            mid();
            chk(tag, 32'(strobes()), 32'(pat[k*4 +: 4]));
            cyc();
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        int         last;
        int         acc;
        int         n;
        int         w;
        bit         seen;
        logic [3:0] exp_wr;

        rst = 1'b1; hold = 1'b0; instr_valid = 1'b0; instr = '0;
        cyc(); cyc();
        rst = 1'b0;
        mid();
        chk("rst_ready", 32'(instr_ready), 32'd1);
        chk("rst_count", 32'(instr_count), 32'd0);
        chk("rst_addr",  32'({R_Addr_A, R_Addr_B, W_Addr}), 32'd0);
        cyc();

        // Basic instruction: ab, f, write, done on cycles +1..+4.
        issue(mk(1, 2, 3, 1, 2));
        expect_strobes("r037_seq", 16'h8421);
        mid();
        chk("r037_addr_a", 32'(R_Addr_A), 32'd1);
        chk("r037_addr_b", 32'(R_Addr_B), 32'd2);
        chk("r037_waddr",  32'(W_Addr),   32'd3);
        chk("r037_aluop",  32'(ALU_OP),   32'd2);
        chk("r037_count",  32'(instr_count), 32'd1);
        cyc();

        // wb=0: no register write, still retires.
        issue(mk(0, 5, 4, 6, 7));
        expect_strobes("r038_seq", 16'h8021);
        mid();
        chk("r038_count", 32'(instr_count), 32'd2);
        cyc();

        // Valid while held in IDLE must be ignored.
        hold = 1'b1; instr_valid = 1'b1; instr = mk(1, 7, 9, 9, 9);
        mid();
        chk("idle_hold_ready", 32'(instr_ready), 32'd0);
        cyc();
        mid();
        chk("idle_hold_busy",  32'(busy),     32'd0);
        chk("idle_hold_addr",  32'(R_Addr_A), 32'd6);
        cyc();
        instr_valid = 1'b0; hold = 1'b0;

        // Hold for three cycles in EXEC.
        issue(mk(1, 9, 10, 11, 12));
        mid();
        chk("r039_ab", 32'(strobes()), 32'd1);
        cyc();
        hold = 1'b1;
        for (int k = 0; k < 3; k++) begin
            mid();
            chk("r039_held", 32'(strobes()), 32'd0);
            cyc();
        end
        hold = 1'b0;
        expect_strobes("r039_release", 16'h0842);
        mid();
        chk("r039_count", 32'(instr_count), 32'd3);
        cyc();

        // Reset during WRITE abandons the instruction.
        issue(mk(1, 3, 13, 14, 15));
        mid(); chk("r040_ab", 32'(strobes()), 32'd1); cyc();
        mid(); chk("r040_f",  32'(strobes()), 32'd2); cyc();
        rst = 1'b1;
        mid();
        chk("r040_wr_blocked", 32'(strobes()), 32'd0);
        cyc();
        rst = 1'b0;
        mid();
        chk("r040_ready", 32'(instr_ready), 32'd1);
        chk("r040_addr",  32'({R_Addr_A, R_Addr_B, W_Addr, ALU_OP}), 32'd0);
        chk("r040_count", 32'(instr_count), 32'd0);
        cyc();
        expect_strobes("r040_quiet", 16'h0000);

        // rd=0 with wb=1: write depends on the protect build option.
        exp_wr = R0_PROT ? 4'h0 : 4'h4;
        issue(mk(1, 1, 0, 2, 3));
        expect_strobes("r041_seq", {4'h8, exp_wr, 4'h2, 4'h1});
        mid();
        chk("r041_count", 32'(instr_count), 32'd1);
        cyc();

        // Back-to-back with valid held high: 17 instructions, 4-bit count wraps.
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        last = -1; acc = 0; n = 0;
        instr_valid = 1'b1;
        while (acc < 17 && n < 200) begin
            instr = mk(n % 2, n % 16, (n + 1) % 32, (n + 2) % 32, (n + 3) % 32);
            mid();
            if (instr_ready) begin
                if (last >= 0) chk("r042_interval", 32'(n - last), 32'd5);
                last = n;
                acc++;
            end
            cyc();
            n++;
        end
        instr_valid = 1'b0;
        if (acc < 17) chk("r042_accepts", 32'(acc), 32'd17);
        seen = 1'b0; w = 0;
        while (!seen && w < 10) begin
            mid();
            if (done) seen = 1'b1;
            cyc();
            w++;
        end
        chk("r042_done_seen", 32'(seen), 32'd1);
        mid();
        chk("r042_wrap", 32'(instr_count), 32'd1);
        chk("r042_idle", 32'(instr_ready), 32'd1);
        cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_alu_seq_ctrl
